spi_xfer_sequencer: RTL and testbench
=====================================

// Module: spi_xfer_sequencer
// PURPOSE
//  Upstream stage of the SPI master core: buffers TX bytes in a FIFO and runs multi-byte commands under chip select.
//  Feeds the core one byte per i_TX_Ready window and collects the core's RX bytes into an RX FIFO.
//  Host side: byte FIFO write/read ports plus a length command. Core side: mirrors the core's TX/RX handshake.
// PARAMETERS
//  FIFO_DEPTH      8  entries in each of the TX and RX FIFOs; power of 2, >=2
//  CS_SETUP_CLKS   2  clk cycles CS_n is low before the first o_TX_DV
//  CS_HOLD_CLKS    2  clk cycles CS_n stays low after the last i_RX_DV
//  CS_IDLE_CLKS    1  minimum clk cycles CS_n stays high before the next command is accepted
//  (derived) CNT_W = $clog2(FIFO_DEPTH+1)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous, active-low reset
//  i_Wr_Data    in   8      TX FIFO write data
//  i_Wr_En      in   1      TX FIFO push; ignored when o_Tx_Full
//  o_Tx_Full    out  1      TX FIFO full
//  o_Tx_Count   out  CNT_W  TX FIFO occupancy
//  o_Rd_Data    out  8      RX FIFO head (first-word fall-through); valid when !o_Rx_Empty
//  i_Rd_En      in   1      RX FIFO pop; ignored when o_Rx_Empty
//  o_Rx_Empty   out  1      RX FIFO empty
//  o_Rx_Count   out  CNT_W  RX FIFO occupancy
//  i_Cmd_Len    in   CNT_W  bytes to transfer in this command
//  i_Cmd_Valid  in   1      command request
//  o_Cmd_Ready  out  1      1 only in IDLE; command taken on i_Cmd_Valid & o_Cmd_Ready
//  o_Cmd_Err    out  1      1-cycle pulse: command rejected
//  o_Done       out  1      1-cycle pulse: command complete, CS_n high for CS_IDLE_CLKS
//  o_Busy       out  1      state != IDLE
//  o_Rx_Ovf     out  1      sticky: RX byte dropped; cleared on next accepted command
//  o_SPI_CS_n   out  1      active-low chip select
//  o_TX_Byte    out  8      to core i_TX_Byte
//  o_TX_DV      out  1      to core i_TX_DV
//  i_TX_Ready   in   1      from core o_TX_Ready
//  i_RX_DV      in   1      from core o_RX_DV
//  i_RX_Byte    in   8      from core o_RX_Byte
// BEHAVIOUR
//  Reset (async): state IDLE, FIFOs empty, CS_n=1, TX_DV=0, TX_Byte=0, Done/Cmd_Err/Busy/Rx_Ovf=0, Cmd_Ready=1, Rx_Empty=1.
//  FIFO push/pop at the same edge: both happen, count unchanged. A push to a full FIFO is dropped even if a pop occurs at the same edge.
//  Command accept: rejected (Cmd_Err pulse next cycle, stay IDLE, CS_n stays 1) if Len==0 or Len>o_Tx_Count.
//  Otherwise: latch rem=Len, clear Rx_Ovf, go to CS_SETUP.
//  CS_SETUP: CS_n=0; after CS_SETUP_CLKS cycles go to LOAD.
//  LOAD: wait for i_TX_Ready=1. At that edge, pop the TX FIFO; next cycle TX_DV=1 for exactly one clk with TX_Byte=popped byte; go to WAIT_RX.
//    TX_DV is never high while i_TX_Ready=0 and is never longer than 1 cycle.
//  WAIT_RX: on i_RX_DV, push i_RX_Byte to the RX FIFO. If the RX FIFO is full, drop the byte and set Rx_Ovf. rem--.
//    If rem!=0 go to LOAD, else go to CS_HOLD.
//  CS_HOLD: CS_n=0 for CS_HOLD_CLKS cycles, then go to CS_IDLE with CS_n=1.
//  CS_IDLE: hold CS_n=1 for CS_IDLE_CLKS cycles. Pulse o_Done on the last cycle, then go to IDLE.
//  CS_n is low continuously from CS_SETUP entry to CS_IDLE entry, with no gaps between bytes.
//  Host TX writes are allowed while busy; bytes beyond rem stay queued for the next command.
//  i_Cmd_Valid while busy: ignored, no error.
//  TX_Byte holds its last value between transfers.
// TESTING
//  T1 reset: assert rst_n=0 mid-idle -> all outputs at reset values, CS_n=1, Cmd_Ready=1 after release.
//  T2 write A5,3C,FF, Len=3, core model loops MOSI->MISO ->
//     3 single-cycle TX_DV pulses with A5,3C,FF, each only while Ready=1;
//     CS_n low throughout; RX FIFO reads A5,3C,FF; one Done pulse; Tx_Count=0.
//  T3 2 bytes queued, Len=4; then Len=0 -> Cmd_Err pulse each time, no TX_DV, CS_n=1, Tx_Count stays 2.
//  T4 RX holds 7 (depth 8), Len=3 -> Rx_Count=8, Rx_Ovf=1, last two RX bytes dropped, Done still pulses.
//  T5 rst_n low one cycle after the 2nd TX_DV of Len=4 -> CS_n=1 immediately, FIFOs empty, no further TX_DV, IDLE.
//  T6 TX FIFO full, command pops while host writes 0x77 same edge -> 0x77 dropped, Tx_Count=FIFO_DEPTH-1.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Host-facing sequencer in front of the SPI master core: TX/RX byte FIFOs plus a CS-framed multi-byte command FSM.
// Latency: command accept to CS_n low is 1 clk; each byte leaves on o_TX_DV 1 clk after i_TX_Ready is seen high in LOAD.
// Backpressure: host pushes to a full TX FIFO are dropped; the FSM waits on i_TX_Ready; RX bytes that hit a full RX FIFO are dropped and flagged.
module spi_xfer_sequencer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int CS_IDLE_CLKS  = 1,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  // host TX FIFO write side
  input  logic [7:0]       i_Wr_Data,
  input  logic             i_Wr_En,
  output logic             o_Tx_Full,
  output logic [CNT_W-1:0] o_Tx_Count,
  // host RX FIFO read side (first-word fall-through)
  output logic [7:0]       o_Rd_Data,
  input  logic             i_Rd_En,
  output logic             o_Rx_Empty,
  output logic [CNT_W-1:0] o_Rx_Count,
  // command interface
  input  logic [CNT_W-1:0] i_Cmd_Len,
  input  logic             i_Cmd_Valid,
  output logic             o_Cmd_Ready,
  output logic             o_Cmd_Err,
  output logic             o_Done,
  output logic             o_Busy,
  output logic             o_Rx_Ovf,
  // SPI master core side
  output logic             o_SPI_CS_n,
  output logic [7:0]       o_TX_Byte,
  output logic             o_TX_DV,
  input  logic             i_TX_Ready,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Timer compare points; every CS_*_CLKS must be at least 1.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CLKS - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CLKS - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_LOAD,
    ST_WAIT_RX,
    ST_CS_HOLD,
    ST_CS_IDLE
  } state_t;

  state_t           state;
  logic [7:0]       tmr;
  logic [CNT_W-1:0] rem;
  logic             cs_n_q;
  logic             tx_dv_q;
  logic [7:0]       tx_byte_q;
  logic             done_q;
  logic             cmd_err_q;
  logic             rx_ovf_q;

  // Both FIFOs share one body; index 0 is the TX FIFO, index 1 the RX FIFO.
  logic [1:0]            f_wr_vld;
  logic [1:0][7:0]       f_wr_dat;
  logic [1:0]            f_rd_rdy;
  logic [1:0][7:0]       f_rd_dat;
  logic [1:0]            f_full;
  logic [1:0]            f_empty;
  logic [1:0][CNT_W-1:0] f_count;

  logic tx_pop;
  logic rx_push;
  logic cmd_bad;

  // The TX FIFO is never empty in LOAD (length was checked at accept), but the guard keeps a stray pop impossible.
  assign tx_pop  = (state == ST_LOAD) && i_TX_Ready && !f_empty[0];
  assign rx_push = (state == ST_WAIT_RX) && i_RX_DV;
  assign cmd_bad = (i_Cmd_Len == '0) || (i_Cmd_Len > f_count[0]);

  assign f_wr_vld = {rx_push, i_Wr_En};
  assign f_wr_dat = {i_RX_Byte, i_Wr_Data};
  assign f_rd_rdy = {i_Rd_En, tx_pop};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_wr;
    logic             do_rd;

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign do_wr = f_wr_vld[g] && (cnt != CNT_W'(FIFO_DEPTH));
    assign do_rd = f_rd_rdy[g] && (cnt != '0);

    // Storage array, no reset needed: entries are only read once written.
    always_ff @(posedge clk) begin
      if (do_wr) begin
        mem[wr_ptr] <= f_wr_dat[g];
      end
    end

    // Pointers wrap naturally because the depth is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_wr) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_rd) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_wr && !do_rd) begin
          cnt <= cnt + 1'b1;
        end else if (do_rd && !do_wr) begin
          cnt <= cnt - 1'b1;
        end
      end
    end

    assign f_rd_dat[g] = mem[rd_ptr];
    assign f_full[g]   = (cnt == CNT_W'(FIFO_DEPTH));
    assign f_empty[g]  = (cnt == '0);
    assign f_count[g]  = cnt;
  end

  // Command FSM: frames each command with CS_n, feeds one byte per ready window and counts RX bytes down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      rem       <= '0;
      cs_n_q    <= 1'b1;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Cmd_Valid) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              rem      <= i_Cmd_Len;
              rx_ovf_q <= 1'b0;
              cs_n_q   <= 1'b0;
              tmr      <= '0;
              state    <= ST_CS_SETUP;
            end
          end
        end
        ST_CS_SETUP: begin
          if (tmr == SETUP_LAST) begin
            tmr   <= '0;
            state <= ST_LOAD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_LOAD: begin
          // The byte is popped on this edge and presented with a single-cycle strobe.
          if (tx_pop) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= f_rd_dat[0];
            state     <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (i_RX_DV) begin
            if (f_full[1]) begin
              rx_ovf_q <= 1'b1;
            end
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              tmr   <= '0;
              state <= ST_CS_HOLD;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_CS_HOLD: begin
          if (tmr == HOLD_LAST) begin
            tmr    <= '0;
            cs_n_q <= 1'b1;
            done_q <= (IDLE_LAST == '0);
            state  <= ST_CS_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_CS_IDLE: begin
          // Done is raised so that it lines up with the final CS-high cycle.
          if (tmr == IDLE_LAST) begin
            tmr   <= '0;
            state <= ST_IDLE;
          end else begin
            tmr    <= tmr + 1'b1;
            done_q <= (8'(tmr + 1'b1) == IDLE_LAST);
          end
        end
        default: begin
          state  <= ST_IDLE;
          cs_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_Tx_Full   = f_full[0];
  assign o_Tx_Count  = f_count[0];
  assign o_Rd_Data   = f_rd_dat[1];
  assign o_Rx_Empty  = f_empty[1];
  assign o_Rx_Count  = f_count[1];
  assign o_Cmd_Ready = (state == ST_IDLE);
  assign o_Busy      = (state != ST_IDLE);
  assign o_Cmd_Err   = cmd_err_q;
  assign o_Done      = done_q;
  assign o_Rx_Ovf    = rx_ovf_q;
  assign o_SPI_CS_n  = cs_n_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_TX_DV     = tx_dv_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a loopback SPI core model.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Protocol monitors count strobe/CS events that the directed checks compare afterwards.
module tb_spi_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_Wr_Data;
  logic       i_Wr_En;
  logic       o_Tx_Full;
  logic [3:0] o_Tx_Count;
  logic [7:0] o_Rd_Data;
  logic       i_Rd_En;
  logic       o_Rx_Empty;
  logic [3:0] o_Rx_Count;
  logic [3:0] i_Cmd_Len;
  logic       i_Cmd_Valid;
  logic       o_Cmd_Ready;
  logic       o_Cmd_Err;
  logic       o_Done;
  logic       o_Busy;
  logic       o_Rx_Ovf;
  logic       o_SPI_CS_n;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       core_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int total = 0;
  int bad   = 0;

  // monitor counters
  int dv_cnt   = 0;
  int dv_bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int cs_fall  = 0;
  int cs_rise  = 0;
  logic prev_dv = 1'b0;
  logic prev_cs = 1'b1;

  logic [7:0] tx_log[$];
  logic [7:0] core_b;
  logic [7:0] exp8 [8];
  int d0, d1, n0, e0, cf0, cr0, n;

  always #5 clk = ~clk;

  spi_xfer_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_Wr_Data   (i_Wr_Data),
    .i_Wr_En     (i_Wr_En),
    .o_Tx_Full   (o_Tx_Full),
    .o_Tx_Count  (o_Tx_Count),
    .o_Rd_Data   (o_Rd_Data),
    .i_Rd_En     (i_Rd_En),
    .o_Rx_Empty  (o_Rx_Empty),
    .o_Rx_Count  (o_Rx_Count),
    .i_Cmd_Len   (i_Cmd_Len),
    .i_Cmd_Valid (i_Cmd_Valid),
    .o_Cmd_Ready (o_Cmd_Ready),
    .o_Cmd_Err   (o_Cmd_Err),
    .o_Done      (o_Done),
    .o_Busy      (o_Busy),
    .o_Rx_Ovf    (o_Rx_Ovf),
    .o_SPI_CS_n  (o_SPI_CS_n),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Ready  (core_ready),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    i_Wr_Data = b;
    i_Wr_En   = 1'b1;
    @(negedge clk);
    i_Wr_En   = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] len);
    i_Cmd_Len   = len;
    i_Cmd_Valid = 1'b1;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, o_Rd_Data, exp);
    i_Rd_En = 1'b1;
    @(negedge clk);
    i_Rd_En = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (o_Done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (k < 400), 1);
  endtask

  // protocol monitor: strobe width, strobe vs ready/CS, done/err pulses, CS edges
  always @(negedge clk) begin
    if (o_TX_DV) begin
      dv_cnt++;
      if (!core_ready || prev_dv || o_SPI_CS_n) dv_bad++;
    end
    prev_dv = o_TX_DV;
    if (o_Done) done_cnt++;
    if (o_Cmd_Err) err_cnt++;
    if (prev_cs && !o_SPI_CS_n) cs_fall++;
    if (!prev_cs && o_SPI_CS_n) cs_rise++;
    prev_cs = o_SPI_CS_n;
  end

  // loopback core model: drops ready on a strobe, returns the same byte a few cycles later
  initial begin
    core_ready = 1'b1;
    rx_dv      = 1'b0;
    rx_byte    = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (o_TX_DV) begin
        core_b     = o_TX_Byte;
        tx_log.push_back(core_b);
        core_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rx_byte = core_b;
        rx_dv   = 1'b1;
        @(negedge clk);
        #1;
        rx_dv      = 1'b0;
        core_ready = 1'b1;
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_Wr_Data   = 8'h00;
    i_Wr_En     = 1'b0;
    i_Rd_En     = 1'b0;
    i_Cmd_Len   = 4'd0;
    i_Cmd_Valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_cs_n", o_SPI_CS_n, 1);
    chk("rst_tx_dv", o_TX_DV, 0);
    chk("rst_tx_byte", o_TX_Byte, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_cmd_err", o_Cmd_Err, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_ovf", o_Rx_Ovf, 0);
    chk("rst_cmd_ready", o_Cmd_Ready, 1);
    chk("rst_rx_empty", o_Rx_Empty, 1);
    chk("rst_tx_count", o_Tx_Count, 0);
    chk("rst_rx_count", o_Rx_Count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: reset while idle with queued bytes
    push(8'h11);
    push(8'h22);
    chk("t1_tx_count_pre", o_Tx_Count, 2);
    rst_n = 1'b0;
    #1;
    chk("t1_tx_count", o_Tx_Count, 0);
    chk("t1_cs_n", o_SPI_CS_n, 1);
    chk("t1_busy", o_Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_cmd_ready", o_Cmd_Ready, 1);
    chk("t1_cs_n_after", o_SPI_CS_n, 1);

    // T2: three-byte loopback command
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    #1;
    d0 = dv_cnt; n0 = done_cnt; cf0 = cs_fall; cr0 = cs_rise;
    tx_log.delete();
    @(negedge clk);
    cmd(4'd3);
    chk("t2_busy", o_Busy, 1);
    chk("t2_cs_low", o_SPI_CS_n, 0);
    chk("t2_cmd_ready", o_Cmd_Ready, 0);
    wait_done("t2_done");
    @(negedge clk);
    #1;
    chk("t2_dv_count", dv_cnt - d0, 3);
    chk("t2_dv_protocol", dv_bad, 0);
    chk("t2_log_size", tx_log.size(), 3);
    chk("t2_byte0", tx_log[0], 8'hA5);
    chk("t2_byte1", tx_log[1], 8'h3C);
    chk("t2_byte2", tx_log[2], 8'hFF);
    chk("t2_done_pulses", done_cnt - n0, 1);
    chk("t2_cs_falls", cs_fall - cf0, 1);
    chk("t2_cs_rises", cs_rise - cr0, 1);
    chk("t2_tx_count", o_Tx_Count, 0);
    chk("t2_rx_count", o_Rx_Count, 3);
    chk("t2_idle", o_Cmd_Ready, 1);
    chk("t2_tx_byte_hold", o_TX_Byte, 8'hFF);
    pop_chk("t2_rx0", 8'hA5);
    pop_chk("t2_rx1", 8'h3C);
    pop_chk("t2_rx2", 8'hFF);
    chk("t2_rx_empty", o_Rx_Empty, 1);

    // T3: rejected commands (too long, zero length)
    push(8'h11);
    push(8'h22);
    #1;
    e0 = err_cnt; d0 = dv_cnt;
    @(negedge clk);
    cmd(4'd4);
    chk("t3_err_len4", o_Cmd_Err, 1);
    chk("t3_busy_len4", o_Busy, 0);
    @(negedge clk);
    chk("t3_err_pulse", o_Cmd_Err, 0);
    cmd(4'd0);
    chk("t3_err_len0", o_Cmd_Err, 1);
    @(negedge clk);
    chk("t3_cs_n", o_SPI_CS_n, 1);
    chk("t3_tx_count", o_Tx_Count, 2);
    #1;
    chk("t3_err_pulses", err_cnt - e0, 2);
    chk("t3_no_dv", dv_cnt - d0, 0);

    // T4: RX overflow; fill RX with 7, then send 3 more
    push(8'h33);
    push(8'h44);
    push(8'h55);
    push(8'h66);
    push(8'h77);
    cmd(4'd7);
    wait_done("t4_fill_done");
    @(negedge clk);
    chk("t4_rx_count7", o_Rx_Count, 7);
    chk("t4_no_ovf", o_Rx_Ovf, 0);
    push(8'h81);
    push(8'h82);
    push(8'h83);
    cmd(4'd3);
    wait_done("t4_done");
    @(negedge clk);
    chk("t4_rx_count8", o_Rx_Count, 8);
    chk("t4_ovf", o_Rx_Ovf, 1);
    chk("t4_tx_count", o_Tx_Count, 0);
    exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33; exp8[3] = 8'h44;
    exp8[4] = 8'h55; exp8[5] = 8'h66; exp8[6] = 8'h77; exp8[7] = 8'h81;
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t4_rx%0d", i), exp8[i]);
    chk("t4_rx_empty", o_Rx_Empty, 1);
    chk("t4_ovf_sticky", o_Rx_Ovf, 1);

    // T5: reset in the middle of a four-byte command
    push(8'h91);
    push(8'h92);
    push(8'h93);
    push(8'h94);
    cmd(4'd4);
    chk("t5_ovf_cleared", o_Rx_Ovf, 0);
    #1;
    d0 = dv_cnt;
    n = 0;
    while ((dv_cnt - d0) < 2 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_two_dv", dv_cnt - d0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_cs_n", o_SPI_CS_n, 1);
    chk("t5_tx_count", o_Tx_Count, 0);
    chk("t5_rx_count", o_Rx_Count, 0);
    chk("t5_busy", o_Busy, 0);
    chk("t5_tx_dv", o_TX_DV, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    d1 = dv_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_no_more_dv", dv_cnt - d1, 0);
    chk("t5_idle", o_Cmd_Ready, 1);
    chk("t5_rx_count_after", o_Rx_Count, 0);

    // T6: push to a full TX FIFO on the same edge as the command pop
    @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    chk("t6_full", o_Tx_Full, 1);
    chk("t6_count8", o_Tx_Count, 8);
    cmd(4'd1);
    @(negedge clk);
    @(negedge clk);
    i_Wr_Data = 8'h77;
    i_Wr_En   = 1'b1;
    @(negedge clk);
    i_Wr_En   = 1'b0;
    chk("t6_pop_edge", o_TX_DV, 1);
    chk("t6_count7", o_Tx_Count, 7);
    chk("t6_not_full", o_Tx_Full, 0);
    wait_done("t6_done1");
    @(negedge clk);
    cmd(4'd7);
    wait_done("t6_done7");
    @(negedge clk);
    chk("t6_tx_drained", o_Tx_Count, 0);
    chk("t6_rx_count", o_Rx_Count, 8);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t6_rx%0d", i), 8'hC0 + 8'(i));
    #1;
    chk("t6_dv_protocol", dv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
